data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dp_pkg.sv | 24 ++
 rtl/dmem_array.sv | 26 ++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared datapath definitions: memory-access FSM states, default wait timing and
// the access-legality rule, shared with the multi-cycle control unit.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_e;

    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int WAIT_CNT_W          = 4;

    // An access is illegal if misaligned, beyond the array, or both read and write.
    function automatic logic isAccessError(input logic [31:0] addr,
                                           input logic        rd,
                                           input logic        wr,
                                           input int          depth);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[31:2]} >= 32'(depth)) ||
               (rd && wr);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
    import dp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory with fixed wait states: accepts one read or write in IDLE, waits
// WAIT_CYCLES cycles, then pulses ready for one cycle with the result or an error.
module data_mem_responder
    import dp_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dir,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ready,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    memState_e             state_q;
    logic [WAIT_CNT_W-1:0] waitCnt_q;
    logic [AW-1:0]         addr_q;
    logic [31:0]           wdata_q;
    logic                  isWrite_q;
    logic                  isErr_q;
    logic [31:0]           dataOut_q;
    logic                  ready_q;
    logic                  err_q;

    logic                  accept;
    logic                  reqErr;
    logic                  arrWe;
    logic [AW-1:0]         arrAddr;
    logic [31:0]           arrRdata;
    logic                  respRead;
    logic                  respErr;
    logic [31:0]           respData_d;

    assign accept = (state_q == IDLE) && (MemRead || MemWrite);
    assign reqErr = isAccessError(dir, MemRead, MemWrite, DEPTH);

    // With zero wait states the response is formed in the accept cycle, so the
    // array is addressed straight from the request while idle.
    assign arrAddr  = (state_q == IDLE) ? dir[AW+1:2] : addr_q;
    assign arrWe    = (state_q == RESP) && isWrite_q && !isErr_q;
    assign respRead = (state_q == IDLE) ? MemRead : !isWrite_q;
    assign respErr  = (state_q == IDLE) ? reqErr  : isErr_q;

    always_comb begin
        respData_d = dataOut_q;
        if (respRead && !respErr) begin
            respData_d = arrRdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arrWe),
        .addr_i  (arrAddr),
        .wdata_i (wdata_q),
        .rdata_o (arrRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            isWrite_q <= 1'b0;
            isErr_q   <= 1'b0;
            dataOut_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= dir[AW+1:2];
                        wdata_q   <= dataIn;
                        isWrite_q <= MemWrite;
                        isErr_q   <= reqErr;
                        if (WAIT_CYCLES > 0) begin
                            state_q   <= WAIT;
                            waitCnt_q <= WAIT_LOAD;
                        end else begin
                            state_q   <= RESP;
                            ready_q   <= 1'b1;
                            err_q     <= respErr;
                            dataOut_q <= respData_d;
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt_q == '0) begin
                        state_q   <= RESP;
                        ready_q   <= 1'b1;
                        err_q     <= respErr;
                        dataOut_q <= respData_d;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut = dataOut_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a default-timing instance (2 wait
// states) and a zero-wait instance, both checked against a word-array model.
module tb_data_mem_responder;

    localparam int DEPTH  = 64;
    localparam int W_FAST = 0;
    localparam int W_SLOW = 2;

    typedef struct {
        int          edgeIdx;
        logic        err;
        logic [31:0] data;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edgeCount = 0;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Index 0 drives the zero-wait instance, index 1 the default instance.
    logic [1:0]       rstN;
    logic [1:0]       memRd;
    logic [1:0]       memWr;
    logic [1:0][31:0] dirS;
    logic [1:0][31:0] dinS;

    logic [31:0] doutF, doutS;
    logic        rdyF, rdyS, errF, errS;

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W_FAST)
    ) dutFast (
        .clk      (clk),
        .rst_n    (rstN[0]),
        .MemRead  (memRd[0]),
        .MemWrite (memWr[0]),
        .dir      (dirS[0]),
        .dataIn   (dinS[0]),
        .dataOut  (doutF),
        .ready    (rdyF),
        .err      (errF)
    );

    data_mem_responder #(
        .DEPTH (DEPTH)
    ) dutSlow (
        .clk      (clk),
        .rst_n    (rstN[1]),
        .MemRead  (memRd[1]),
        .MemWrite (memWr[1]),
        .dir      (dirS[1]),
        .dataIn   (dinS[1]),
        .dataOut  (doutS),
        .ready    (rdyS),
        .err      (errS)
    );

    exp_t        qFast[$];
    exp_t        qSlow[$];
    logic [31:0] refMem [2][DEPTH];
    logic [31:0] refOut [2];

    int total = 0;
    int bad   = 0;

    function automatic int waitOf(input int which);
        return (which == 0) ? W_FAST : W_SLOW;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
        end
    endtask

    // Drive one request, predict its response from the memory model, then keep
    // scrambling the inputs until the access has finished so they must be ignored.
    task automatic applyStimulus(input int which, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_t x;
        logic e;
        int   idx;
        memRd[which] = r;
        memWr[which] = w;
        dirS[which]  = a;
        dinS[which]  = d;
        e   = ((a % 4) != 0) || ((a >> 2) >= 32'(DEPTH)) || (r && w);
        idx = int'(a >> 2);
        if (!e && r) refOut[which] = refMem[which][idx];
        if (!e && w) refMem[which][idx] = d;
        x.edgeIdx = edgeCount + 1 + waitOf(which);
        x.err     = e;
        x.data    = refOut[which];
        x.tag     = tag;
        if (which == 0) qFast.push_back(x);
        else            qSlow.push_back(x);
        repeat (waitOf(which) + 1) begin
            @(negedge clk);
            memRd[which] = 1'($urandom);
            memWr[which] = 1'($urandom);
            dirS[which]  = $urandom;
            dinS[which]  = $urandom;
        end
        @(negedge clk);
        memRd[which] = 1'b0;
        memWr[which] = 1'b0;
        dirS[which]  = '0;
        dinS[which]  = '0;
    endtask

    task automatic randomOp(input int which, input int words);
        int          k;
        logic [31:0] a;
        logic        r, w;
        k = $urandom_range(0, 9);
        a = 32'($urandom_range(0, words - 1)) << 2;
        r = 1'b1;
        w = 1'b0;
        case (k)
            4, 5, 6: begin r = 1'b0; w = 1'b1; end
            7: begin
                a = a + $urandom_range(1, 3);
                r = 1'($urandom);
                w = !r;
            end
            8: begin
                a = ($urandom() | 32'h100) & ~32'h3;
                r = 1'($urandom);
                w = !r;
            end
            9: begin r = 1'b1; w = 1'b1; end
            default: begin r = 1'b1; w = 1'b0; end
        endcase
        applyStimulus(which, r, w, a, $urandom, "rand");
    endtask

    // Accept a write on the default instance, then pull reset while it waits.
    task automatic resetAbort(input logic [31:0] a, input logic [31:0] d);
        memRd[1] = 1'b0;
        memWr[1] = 1'b1;
        dirS[1]  = a;
        dinS[1]  = d;
        @(negedge clk);
        memWr[1] = 1'b0;
        rstN[1]  = 1'b0;
        #1;
        checkVal("abort.ready", 32'(rdyS), 32'd0);
        checkVal("abort.err", 32'(errS), 32'd0);
        checkVal("abort.dataOut", doutS, 32'd0);
        repeat (3) @(negedge clk);
        checkVal("abort.readyHeld", 32'(rdyS), 32'd0);
        checkVal("abort.dataOutHeld", doutS, 32'd0);
        refOut[1] = '0;
        rstN[1]   = 1'b1;
    endtask

    // Monitor: every response must match the oldest prediction, arrive on the
    // predicted edge, and err must stay low outside a ready pulse.
    task automatic checkOutput(input int which, input logic rdy, input logic e, input logic [31:0] dout);
        exp_t  head;
        logic  have;
        string nm;
        nm   = (which == 0) ? "fast" : "slow";
        have = 1'b0;
        if (which == 0) begin
            if (qFast.size() > 0) begin have = 1'b1; head = qFast[0]; end
        end else begin
            if (qSlow.size() > 0) begin have = 1'b1; head = qSlow[0]; end
        end
        if (have && (edgeCount > head.edgeIdx)) begin
            total++;
            bad++;
            $display("[TB] FAIL %s.%s.missingReady: no ready by edge %0d, now edge %0d",
                     nm, head.tag, head.edgeIdx, edgeCount);
            if (which == 0) void'(qFast.pop_front());
            else            void'(qSlow.pop_front());
            return;
        end
        if (!rdy) begin
            checkVal({nm, ".errWithoutReady"}, 32'(e), 32'd0);
            return;
        end
        if (!have) begin
            total++;
            bad++;
            $display("[TB] FAIL %s.unexpectedReady: ready=1 at edge %0d, want no response", nm, edgeCount);
            return;
        end
        if (which == 0) void'(qFast.pop_front());
        else            void'(qSlow.pop_front());
        checkVal({nm, ".", head.tag, ".readyEdge"}, 32'(edgeCount), 32'(head.edgeIdx));
        checkVal({nm, ".", head.tag, ".err"}, 32'(e), 32'(head.err));
        checkVal({nm, ".", head.tag, ".dataOut"}, dout, head.data);
    endtask

    always @(negedge clk) checkOutput(0, rdyF, errF, doutF);
    always @(negedge clk) checkOutput(1, rdyS, errS, doutS);

    initial begin
        rstN  = 2'b00;
        memRd = '0;
        memWr = '0;
        dirS  = '0;
        dinS  = '0;
        repeat (3) @(negedge clk);
        checkVal("rst.slow.dataOut", doutS, 32'd0);
        checkVal("rst.slow.ready", 32'(rdyS), 32'd0);
        checkVal("rst.slow.err", 32'(errS), 32'd0);
        checkVal("rst.fast.dataOut", doutF, 32'd0);
        checkVal("rst.fast.ready", 32'(rdyF), 32'd0);
        checkVal("rst.fast.err", 32'(errF), 32'd0);
        refOut[0] = '0;
        refOut[1] = '0;
        rstN = 2'b11;

        // Default instance: fill, directed corner cases, abort, then random traffic.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1'b0, 1'b1, 32'(i * 4), $urandom, "init");
        applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, "rd10");
        applyStimulus(1, 1'b1, 1'b0, 32'h12, 32'h0, "rdUnaligned");
        applyStimulus(1, 1'b0, 1'b1, 32'h12, 32'h11111111, "wrUnaligned");
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, "rd10Again");
        applyStimulus(1, 1'b0, 1'b1, 32'hFC, 32'hA5A5_5A5A, "wrLastWord");
        applyStimulus(1, 1'b1, 1'b0, 32'hFC, 32'h0, "rdLastWord");
        applyStimulus(1, 1'b1, 1'b0, 32'h100, 32'h0, "rdPastEnd");
        applyStimulus(1, 1'b0, 1'b1, 32'h100, 32'h22222222, "wrPastEnd");
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, "rdWord0");
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h12345678, "bothHigh");
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, "rd20");
        applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, "rd30Before");
        resetAbort(32'h30, 32'hCAFEF00D);
        applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, "rd30AfterAbort");
        for (int i = 0; i < 250; i++) randomOp(1, DEPTH);

        // Zero-wait instance: fill a few words, then back-to-back traffic.
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, 1'b1, 32'(i * 4), $urandom, "init");
        for (int i = 0; i < 40; i++)
            applyStimulus(0, 1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, $urandom, "b2bRead");
        for (int i = 0; i < 60; i++) randomOp(0, 16);

        repeat (8) @(negedge clk);
        checkVal("drain.fast.pending", 32'(qFast.size()), 32'd0);
        checkVal("drain.slow.pending", 32'(qSlow.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
